bsram_arbiter: RTL and testbench
================================

Name: bsram_arbiter

Overview:
- Two-requester arbiter that shares one BSRAM read/write port between two clients, e.g. instruction fetch and load/store, or two cores on a shared scratchpad.
- Round-robin grant with an optional bounded burst lock.
- Drives the BSRAM port directly and returns read data one cycle after grant through a registered response.
- Sits between the requesters and a single same-cycle-read BSRAM instance.

Parameters:
- CORE, 0, core index; informational, carried for consistency with the memory it fronts.
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 8, word address width; matches the attached BSRAM.
- BURST_MAX, 4, maximum consecutive grants to one locked requester while the other is waiting; must be >= 1.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clock.
- req0 / req1  input  1  access request from requester 0 / 1; held until granted.
- we0 / we1  input  1  1 = write, 0 = read; valid while the corresponding req is high.
- addr0 / addr1  input  ADDR_WIDTH  word address.
- wdata0 / wdata1  input  DATA_WIDTH  write data.
- lock0 / lock1  input  1  request to retain the grant on following cycles (burst).
- gnt0 / gnt1  output  1  combinational grant; the access completes in this cycle.
- rvalid0 / rvalid1  output  1  registered read response valid, one cycle after a read grant.
- rdata0 / rdata1  output  DATA_WIDTH  registered read data; holds its last value when rvalid is low.
- mem_readEnable  output  1  to BSRAM readEnable.
- mem_readAddress  output  ADDR_WIDTH  to BSRAM readAddress.
- mem_readData  input  DATA_WIDTH  from BSRAM readData (same-cycle combinational).
- mem_writeEnable  output  1  to BSRAM writeEnable.
- mem_writeAddress  output  ADDR_WIDTH  to BSRAM writeAddress.
- mem_writeData  output  DATA_WIDTH  to BSRAM writeData.

Behaviour:

Reset (while reset == 0):
- Outputs: gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0, mem_readEnable = mem_writeEnable = 0.
- Internal state: priority pointer prio = 0 (port 0 preferred), burst_cnt = 0, owner state = FREE.
- Reset asserted mid-burst: the burst is abandoned, there are no grants that cycle, and a pending rvalid is cleared on the next edge.

Arbitration (combinational, evaluated each cycle):
- At most one grant per cycle; gnt0 & gnt1 is never 1.
- State FREE:
  - Only one req high: that port is granted.
  - Both high: port prio is granted.
- State LOCKED(p):
  - Port p is granted if req_p is high and (the other req is low, or burst_cnt < BURST_MAX).
  - Otherwise the other port is granted.
- Port mux:
  - Granted read: mem_readEnable = 1, mem_readAddress = addr of the granted port, mem_writeEnable = 0.
  - Granted write: mem_writeEnable = 1, mem_writeAddress/mem_writeData from the granted port, mem_readEnable = 0.
  - No grant: both enables 0; address/data outputs are don't-care, driven 0.

Sequential update (rising edge, reset == 1):
- prio:
  - After a grant to port p, prio = 1-p.
  - When both ports are idle, prio is unchanged.
- Owner state:
  - After a grant to port p with lock_p = 1, the state becomes LOCKED(p).
  - Otherwise the state becomes FREE.
- burst_cnt:
  - Increments on a grant to the same LOCKED owner.
  - Loads 1 on entry to LOCKED.
  - Clears to 0 on FREE or on a handover.
  - Saturates at BURST_MAX.
- Forced rotation: when a locked owner is denied because burst_cnt == BURST_MAX and the other port is requesting, ownership moves to FREE and the other port is granted that cycle.
- Lock release: lock_p low, or req_p low while LOCKED(p), returns the state to FREE on the next edge.

Read response:
- On a read grant to port p: rvalid_p <= 1 and rdata_p <= mem_readData on the same edge.
- rvalid is a single-cycle pulse per granted read.
- Back-to-back read grants give back-to-back rvalid pulses.

Writes:
- Complete at the grant edge.
- No response pulse.

Same-address traffic:
- A write followed by a read to the same address on consecutive cycles returns the new data, because the write commits at the first edge.

Throughput and latency:
- Throughput is one access per cycle.
- Latency from grant to rdata is 1 cycle.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with req0 = req1 = 1 -> gnt0 = gnt1 = 0, rvalid = 0, mem enables = 0. Release reset -> gnt0 = 1 first.
- Single requester: req0 write addr 0x10 data 0xDEADBEEF, then req0 read 0x10 -> gnt0 both cycles, rvalid0 = 1 and rdata0 = 0xDEADBEEF one cycle after the read grant.
- Contention: req0 = req1 = 1 reads held for 6 cycles, no lock -> grants alternate 0,1,0,1,0,1, and each port receives 3 rvalid pulses.
- Burst: BURST_MAX = 4, lock1 = 1, req1 held, req0 asserted from the second cycle -> gnt1 for 4 consecutive cycles, then gnt0. With lock0 = 0, gnt1 resumes the cycle after.
- Mid-burst reset: LOCKED(0) with burst_cnt = 2, reset = 0 for 1 cycle -> no grant that cycle, and state FREE/prio = 0 afterwards. With both ports requesting on the next cycle -> gnt0.
- Read-after-write across ports: port 1 writes 0x55 to addr 0x20, and port 0 reads addr 0x20 on the next grant -> rdata0 = 0x55.

Source files
------------

// File: rtl/bsram_arbiter.sv
// Two-requester round-robin arbiter sharing one same-cycle-read BSRAM port.
// Supports a bounded burst lock per requester; read data is returned one cycle after grant.
module bsram_arbiter #(
  parameter int unsigned CORE       = 0,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_readEnable,
  output logic [ADDR_WIDTH-1:0] mem_readAddress,
  input  logic [DATA_WIDTH-1:0] mem_readData,
  output logic                  mem_writeEnable,
  output logic [ADDR_WIDTH-1:0] mem_writeAddress,
  output logic [DATA_WIDTH-1:0] mem_writeData
);

  localparam int unsigned CntW = $clog2(BURST_MAX + 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(BURST_MAX);

  localparam logic [1:0] ST_FREE  = 2'b00;
  localparam logic [1:0] ST_LOCK0 = 2'b01;
  localparam logic [1:0] ST_LOCK1 = 2'b10;

  logic [1:0]            r_state;
  logic [CntW-1:0]       r_burst_cnt;
  logic                  r_prio;
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic [1:0]            w_state_nxt;
  logic [CntW-1:0]       w_cnt_nxt;
  logic                  w_prio_nxt;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_any;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_unused_core;

  assign w_unused_core = (CORE == 0);

  // Grant selection; nothing is granted while reset is asserted.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset) begin
      case (r_state)
        ST_LOCK0: begin
          if (req0 && (!req1 || (r_burst_cnt < BurstMax))) w_gnt0 = 1'b1;
          else if (req1)                                  w_gnt1 = 1'b1;
        end
        ST_LOCK1: begin
          if (req1 && (!req0 || (r_burst_cnt < BurstMax))) w_gnt1 = 1'b1;
          else if (req0)                                  w_gnt0 = 1'b1;
        end
        default: begin
          if (req0 && req1) begin
            w_gnt0 = ~r_prio;
            w_gnt1 = r_prio;
          end else begin
            w_gnt0 = req0;
            w_gnt1 = req1;
          end
        end
      endcase
    end
  end

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign w_any   = w_gnt0 | w_gnt1;
  assign w_we    = w_gnt1 ? we1 : we0;
  assign w_addr  = w_gnt1 ? addr1 : addr0;
  assign w_wdata = w_gnt1 ? wdata1 : wdata0;

  assign mem_readEnable   = w_any & ~w_we;
  assign mem_writeEnable  = w_any & w_we;
  assign mem_readAddress  = mem_readEnable ? w_addr : '0;
  assign mem_writeAddress = mem_writeEnable ? w_addr : '0;
  assign mem_writeData    = mem_writeEnable ? w_wdata : '0;

  // Ownership, burst counter and round-robin pointer for the next cycle.
  always_comb begin
    w_state_nxt = ST_FREE;
    w_cnt_nxt   = '0;
    w_prio_nxt  = r_prio;
    if (w_gnt0) begin
      w_prio_nxt = 1'b1;
      if (lock0) begin
        w_state_nxt = ST_LOCK0;
        if (r_state != ST_LOCK0)          w_cnt_nxt = CntW'(1);
        else if (r_burst_cnt == BurstMax) w_cnt_nxt = r_burst_cnt;
        else                              w_cnt_nxt = r_burst_cnt + CntW'(1);
      end
    end else if (w_gnt1) begin
      w_prio_nxt = 1'b0;
      if (lock1) begin
        w_state_nxt = ST_LOCK1;
        if (r_state != ST_LOCK1)          w_cnt_nxt = CntW'(1);
        else if (r_burst_cnt == BurstMax) w_cnt_nxt = r_burst_cnt;
        else                              w_cnt_nxt = r_burst_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_FREE;
      r_burst_cnt <= '0;
      r_prio      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_cnt_nxt;
      r_prio      <= w_prio_nxt;
      r_rvalid0   <= w_gnt0 & ~we0;
      r_rvalid1   <= w_gnt1 & ~we1;
      if (w_gnt0 && !we0) r_rdata0 <= mem_readData;
      if (w_gnt1 && !we1) r_rdata1 <= mem_readData;
    end
  end

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_bsram_arbiter.sv
// Scoreboard bench for bsram_arbiter: reference arbitration model plus a queue-based read checker.
module tb_bsram_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int BURST = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_readEnable, mem_writeEnable;
  logic [AW-1:0] mem_readAddress, mem_writeAddress;
  logic [DW-1:0] mem_readData, mem_writeData;

  always #5 clock = ~clock;

  bsram_arbiter #(
    .CORE       (0),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BURST_MAX  (BURST)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req0             (req0),
    .req1             (req1),
    .we0              (we0),
    .we1              (we1),
    .addr0            (addr0),
    .addr1            (addr1),
    .wdata0           (wdata0),
    .wdata1           (wdata1),
    .lock0            (lock0),
    .lock1            (lock1),
    .gnt0             (gnt0),
    .gnt1             (gnt1),
    .rvalid0          (rvalid0),
    .rvalid1          (rvalid1),
    .rdata0           (rdata0),
    .rdata1           (rdata1),
    .mem_readEnable   (mem_readEnable),
    .mem_readAddress  (mem_readAddress),
    .mem_readData     (mem_readData),
    .mem_writeEnable  (mem_writeEnable),
    .mem_writeAddress (mem_writeAddress),
    .mem_writeData    (mem_writeData)
  );

  // Attached BSRAM: synchronous write, same-cycle combinational read.
  logic [DW-1:0] bram [256];
  always @(posedge clock) if (mem_writeEnable) bram[mem_writeAddress] <= mem_writeData;
  assign mem_readData = bram[mem_readAddress];

  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int total = 0;
  int bad   = 0;

  // Reference state: owner -1 means nobody holds a burst.
  int m_owner  = -1;
  int m_streak = 0;
  int m_prio   = 0;
  int last_g   = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r0, input bit w0, input int a0, input logic [DW-1:0] d0,
                       input bit l0, input bit r1, input bit w1, input int a1,
                       input logic [DW-1:0] d1, input bit l1);
    req0 = r0; we0 = w0; addr0 = AW'(a0); wdata0 = d0; lock0 = l0;
    req1 = r1; we1 = w1; addr1 = AW'(a1); wdata1 = d1; lock1 = l1;
  endtask

  // One clock cycle: predict the grant from the rules, compare, then advance the model.
  task automatic step();
    bit            rq[2], lk[2], wr[2];
    logic [AW-1:0] ad[2];
    logic [DW-1:0] wd[2];
    logic [49:0]   exp_port;
    int g, o;
    @(negedge clock);
    rq[0] = req0; rq[1] = req1; lk[0] = lock0; lk[1] = lock1; wr[0] = we0; wr[1] = we1;
    ad[0] = addr0; ad[1] = addr1; wd[0] = wdata0; wd[1] = wdata1;
    g = -1;
    if (reset) begin
      if (m_owner < 0) begin
        if (rq[0] && rq[1]) g = m_prio;
        else if (rq[0])     g = 0;
        else if (rq[1])     g = 1;
      end else begin
        o = 1 - m_owner;
        if (rq[m_owner] && (!rq[o] || m_streak < BURST)) g = m_owner;
        else if (rq[o])                                  g = o;
      end
    end
    check("grant", 64'({gnt1, gnt0}), (g < 0) ? 64'd0 : 64'(1 << g));
    exp_port = '0;
    if (g >= 0) begin
      if (wr[g]) exp_port = {1'b0, 1'b1, 8'h00, ad[g], wd[g]};
      else       exp_port = {1'b1, 1'b0, ad[g], 8'h00, 32'h0};
    end
    check("memport", 64'({mem_readEnable, mem_writeEnable, mem_readAddress, mem_writeAddress,
                          mem_writeData}), 64'(exp_port));
    if (g >= 0) begin
      if (wr[g]) ref_mem[ad[g]] = wd[g];
      else if (g == 0) exp_q0.push_back(ref_mem[ad[g]]);
      else exp_q1.push_back(ref_mem[ad[g]]);
    end
    if (!reset) begin
      m_owner = -1; m_streak = 0; m_prio = 0;
    end else if (g >= 0) begin
      m_prio = 1 - g;
      if (lk[g]) begin
        m_streak = (m_owner == g) ? ((m_streak < BURST) ? m_streak + 1 : BURST) : 1;
        m_owner  = g;
      end else begin
        m_owner = -1; m_streak = 0;
      end
    end else begin
      m_owner = -1; m_streak = 0;
    end
    last_g = g;
    @(posedge clock);
    #1;
  endtask

  // Monitor: every rvalid pulse must match the oldest expected read for that port.
  logic [DW-1:0] hold0 = '0, hold1 = '0;
  initial begin
    logic rst_s;
    forever begin
      @(negedge clock);
      rst_s = reset;
      @(posedge clock);
      #2;
      if (!rst_s) begin
        hold0 = '0; hold1 = '0;
      end
      if (rvalid0) begin
        if (exp_q0.size() == 0) begin
          total++; bad++;
          $display("FAIL rvalid0: got unexpected pulse expected none");
        end else begin
          hold0 = exp_q0.pop_front();
          check("rdata0", 64'(rdata0), 64'(hold0));
        end
      end else check("rdata0_hold", 64'(rdata0), 64'(hold0));
      if (rvalid1) begin
        if (exp_q1.size() == 0) begin
          total++; bad++;
          $display("FAIL rvalid1: got unexpected pulse expected none");
        end else begin
          hold1 = exp_q1.pop_front();
          check("rdata1", 64'(rdata1), 64'(hold1));
        end
      end else check("rdata1_hold", 64'(rdata1), 64'(hold1));
    end
  end

  initial begin
    bit p[2];
    for (int i = 0; i < 256; i++) begin
      bram[i]    = $urandom;
      ref_mem[i] = bram[i];
    end
    #1;
    // Reset held with both ports requesting.
    reset = 1'b0;
    drive(1, 0, 1, 0, 0, 1, 0, 2, 0, 0);
    for (int i = 0; i < 3; i++) step();
    check("rst_rvalid", 64'({rvalid1, rvalid0}), 64'd0);
    check("rst_rdata", 64'({rdata1, rdata0}), 64'd0);
    reset = 1'b1;
    step();
    // Single requester write then read.
    drive(1, 1, 'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 'h10, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    // Contention without lock.
    drive(1, 0, 3, 0, 0, 1, 0, 4, 0, 0);
    for (int i = 0; i < 6; i++) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    // Burst lock on port 1, port 0 joins a cycle later.
    drive(0, 0, 5, 0, 0, 1, 0, 6, 0, 1);
    step();
    drive(1, 0, 5, 0, 0, 1, 0, 6, 0, 1);
    for (int i = 0; i < 6; i++) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    // Reset in the middle of a port 0 burst.
    drive(1, 0, 7, 0, 1, 0, 0, 0, 0, 0);
    step();
    step();
    drive(1, 0, 7, 0, 1, 1, 0, 8, 0, 0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    // Read-after-write across ports.
    drive(0, 0, 0, 0, 0, 1, 1, 'h20, 32'h55, 0);
    step();
    drive(1, 0, 'h20, 0, 0, 0, 0, 0, 0, 0);
    step();
    // Randomized traffic; a request is held until the model grants it.
    p[0] = 0; p[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!p[0] && ($urandom_range(9) < 6)) begin
        p[0] = 1; we0 = $urandom_range(1); addr0 = AW'($urandom_range(15));
        wdata0 = $urandom; lock0 = ($urandom_range(9) < 6);
      end
      if (!p[1] && ($urandom_range(9) < 6)) begin
        p[1] = 1; we1 = $urandom_range(1); addr1 = AW'($urandom_range(15));
        wdata1 = $urandom; lock1 = ($urandom_range(9) < 6);
      end
      req0 = p[0]; req1 = p[1];
      reset = ($urandom_range(79) != 0);
      step();
      if (last_g == 0) p[0] = 0;
      if (last_g == 1) p[1] = 0;
    end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    check("pending_reads", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
